// File: rtl/irq_encoder8_3.sv
// ---------------------------------------------------------------------------
// irq_encoder8_3
//
// Registered 8-to-3 priority encoder with sticky request capture and a
// valid/ack handshake toward a single consumer (control unit / exception
// sequencer). Event lines are OR-ed into a pending register. One pending
// index at a time is presented on `code` with `valid` high. An ack retires
// that index and clears its pending bit.
//
// Parameters
//   ROUND_ROBIN : 0 = fixed priority, index 0 highest
//                 1 = rotating priority, scan starts just above the last
//                     acknowledged index and wraps 7 -> 0
//   RESET_LAST  : last-acknowledged index after reset (7 makes 0 win first)
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   req      in   [7:0] event lines; a high bit sets the matching pending bit
//   enable   in   1 = capture requests and start presentations
//   flush    in   synchronous clear of pending/overrun, drops presentation
//   ack      in   consumer accepts current code (only while valid)
//   code     out  [2:0] index being presented (defined while valid)
//   valid    out  code holds a pending request awaiting ack
//   pending  out  [7:0] registered pending set
//   overrun  out  sticky: a request arrived on an already-pending line
// ---------------------------------------------------------------------------
module irq_encoder8_3 #(
  parameter bit         ROUND_ROBIN = 1'b0,
  parameter logic [2:0] RESET_LAST  = 3'd7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] req,
  input  logic       enable,
  input  logic       flush,
  input  logic       ack,
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] pending,
  output logic       overrun
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t     state_q,   state_d;
  logic [2:0] code_q,    code_d;
  logic [2:0] last_q,    last_d;
  logic [7:0] pending_q, pending_d;
  logic       overrun_q, overrun_d;

  // -------------------------------------------------------------------------
  // Selection scanner. Both modes use the same upward scan; fixed priority
  // simply starts at index 0, round-robin starts just above the last ack.
  // The 3-bit start + offset sum wraps 7 -> 0 naturally. Selection looks at
  // the registered pending set only, never at this cycle's req.
  // -------------------------------------------------------------------------
  logic [2:0] scan_start;
  logic [2:0] scan_idx;
  logic [2:0] sel_idx;
  logic       sel_found;

  assign scan_start = ROUND_ROBIN ? (last_q + 3'd1) : 3'd0;

  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    sel_found = 1'b0;
    sel_idx   = 3'd0;
    scan_idx  = scan_start;
    for (int k = 0; k < 8; k++) begin
      scan_idx = scan_start + 3'(k);
      if (!sel_found && pending_q[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Ack clear mask: one-hot of the presented index, only while presenting.
  // An ack seen in IDLE has no effect.
  // -------------------------------------------------------------------------
  logic       ack_take;
  logic [7:0] clr_mask;

  assign ack_take = (state_q == ST_PRESENT) && ack;
  assign clr_mask = ack_take ? (8'd1 << code_q) : 8'd0;

  // -------------------------------------------------------------------------
  // Next-state logic: pending capture, overrun, and the IDLE/PRESENT FSM.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    last_d    = last_q;
    overrun_d = overrun_q;
    // The ack clear is applied whether or not capture is enabled, so a
    // presentation started before enable dropped can still be retired.
    pending_d = pending_q & ~clr_mask;

    if (enable) begin
      // OR-ing req after the clear makes a same-cycle request on the acked
      // line win: the bit stays pending and will be presented again.
      pending_d = pending_d | req;
      if ((req & pending_q & ~clr_mask) != 8'd0) begin
        overrun_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (enable && sel_found) begin
          code_d  = sel_idx;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        // code is held stable; no re-arbitration until the consumer acks.
        if (ack) begin
          last_d  = code_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush overrides everything above. code and last keep their values;
    // the discarded ack does not count as an acknowledgement.
    if (flush) begin
      pending_d = 8'd0;
      overrun_d = 1'b0;
      state_d   = ST_IDLE;
      code_d    = code_q;
      last_d    = last_q;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: every register here, including code and last, is small control
    // state that must reach a known value on reset. State registers use
    // non-blocking assignments so all of them update together on the edge.
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      code_q    <= 3'd0;
      last_q    <= RESET_LAST;
      pending_q <= 8'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      last_q    <= last_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs come straight from registers.
  assign code    = code_q;
  assign valid   = (state_q == ST_PRESENT);
  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_irq_encoder8_3.sv
// ---------------------------------------------------------------------------
// tb_irq_encoder8_3
//
// Drives a fixed-priority instance (dut_f) and a round-robin instance
// (dut_r) from the same stimulus. Directed scenario tasks check the
// documented behaviour with literal expectations; a randomized task compares
// both instances every cycle against a per-mode behavioural model.
// ---------------------------------------------------------------------------
module tb_irq_encoder8_3;

  logic       clk;
  logic       reset_n;
  logic [7:0] req;
  logic       enable;
  logic       flush;
  logic       ack;

  logic [2:0] f_code,    r_code;
  logic       f_valid,   r_valid;
  logic [7:0] f_pending, r_pending;
  logic       f_overrun, r_overrun;

  int checks = 0;
  int errors = 0;

  irq_encoder8_3 #(.ROUND_ROBIN(1'b0), .RESET_LAST(3'd7)) dut_f (
    .clk(clk), .reset_n(reset_n), .req(req), .enable(enable),
    .flush(flush), .ack(ack), .code(f_code), .valid(f_valid),
    .pending(f_pending), .overrun(f_overrun)
  );

  irq_encoder8_3 #(.ROUND_ROBIN(1'b1), .RESET_LAST(3'd7)) dut_r (
    .clk(clk), .reset_n(reset_n), .req(req), .enable(enable),
    .flush(flush), .ack(ack), .code(r_code), .valid(r_valid),
    .pending(r_pending), .overrun(r_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Reference model, index 0 = fixed priority, 1 = round-robin.
  // -------------------------------------------------------------------------
  logic [7:0] m_pend  [2];
  int         m_code  [2];
  int         m_last  [2];
  bit         m_valid [2];
  bit         m_ovr   [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m]  = 8'h00;
      m_code[m]  = 0;
      m_last[m]  = 7;
      m_valid[m] = 1'b0;
      m_ovr[m]   = 1'b0;
    end
  endtask

  // One clock edge of the documented rules, using the inputs as they stood.
  task automatic model_step();
    logic [7:0] clr;
    logic [7:0] next_pend;
    int idx;
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      if (flush) begin
        m_pend[m]  = 8'h00;
        m_ovr[m]   = 1'b0;
        m_valid[m] = 1'b0;
      end else begin
        clr = (m_valid[m] && ack) ? 8'(1 << m_code[m]) : 8'h00;
        next_pend = m_pend[m] & ~clr;
        if (enable) begin
          if ((req & m_pend[m] & ~clr) != 8'h00) m_ovr[m] = 1'b1;
          next_pend = next_pend | req;
        end
        if (m_valid[m]) begin
          if (ack) begin
            m_last[m]  = m_code[m];
            m_valid[m] = 1'b0;
          end
        end else if (enable && m_pend[m] != 8'h00) begin
          for (int k = 0; k < 8; k++) begin
            idx = (m == 1) ? (m_last[m] + 1 + k) % 8 : k;
            if (!m_valid[m] && m_pend[m][idx]) begin
              m_code[m]  = idx;
              m_valid[m] = 1'b1;
            end
          end
        end
        m_pend[m] = next_pend;
      end
    end
  endtask

  // Advance one clock edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    req     = 8'h00;
    enable  = 1'b1;
    flush   = 1'b0;
    ack     = 1'b0;
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    #2;
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL reset_f_valid got %b want 0", f_valid); end
    checks++; if (f_code !== 3'd0) begin errors++; $display("FAIL reset_f_code got %0d want 0", f_code); end
    checks++; if (f_pending !== 8'h00) begin errors++; $display("FAIL reset_f_pending got %h want 00", f_pending); end
    checks++; if (f_overrun !== 1'b0) begin errors++; $display("FAIL reset_f_overrun got %b want 0", f_overrun); end
    checks++; if (r_valid !== 1'b0 || r_pending !== 8'h00) begin errors++; $display("FAIL reset_r got valid %b pending %h want 0/00", r_valid, r_pending); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h20;
    tick();
    req = 8'h00;
    checks++; if (f_pending !== 8'h20) begin errors++; $display("FAIL single_pending got %h want 20", f_pending); end
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early got %b want 0", f_valid); end
    tick();
    checks++; if (f_valid !== 1'b1 || f_code !== 3'd5) begin errors++; $display("FAIL single_present got valid %b code %0d want 1/5", f_valid, f_code); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (f_valid !== 1'b0 || f_pending !== 8'h00) begin errors++; $display("FAIL single_ack got valid %b pending %h want 0/00", f_valid, f_pending); end
  endtask

  task automatic test_fixed_priority();
    int exp_codes [3] = '{0, 4, 7};
    do_reset();
    req = 8'h91;
    tick();
    req = 8'h00;
    tick();
    checks++; if (f_valid !== 1'b1 || f_code !== 3'(exp_codes[0])) begin errors++; $display("FAIL fixed_first got valid %b code %0d want 1/0", f_valid, f_code); end
    for (int i = 0; i < 3; i++) begin
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL fixed_gap%0d got valid %b want 0", i, f_valid); end
      if (i < 2) begin
        tick();
        checks++; if (f_valid !== 1'b1 || f_code !== 3'(exp_codes[i+1])) begin errors++; $display("FAIL fixed_code%0d got valid %b code %0d want 1/%0d", i + 1, f_valid, f_code, exp_codes[i+1]); end
      end
    end
    checks++; if (f_pending !== 8'h00) begin errors++; $display("FAIL fixed_drain got %h want 00", f_pending); end
  endtask

  task automatic test_round_robin();
    int exp_codes [3] = '{7, 0, 7};
    do_reset();
    req = 8'h81;
    tick();
    checks++; if (r_pending !== 8'h81 || r_overrun !== 1'b0) begin errors++; $display("FAIL rr_capture got pending %h overrun %b want 81/0", r_pending, r_overrun); end
    tick();
    checks++; if (r_valid !== 1'b1 || r_code !== 3'd0) begin errors++; $display("FAIL rr_first got valid %b code %0d want 1/0", r_valid, r_code); end
    checks++; if (r_overrun !== 1'b1) begin errors++; $display("FAIL rr_overrun got %b want 1", r_overrun); end
    for (int i = 0; i < 3; i++) begin
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL rr_gap%0d got valid %b want 0", i, r_valid); end
      tick();
      checks++; if (r_valid !== 1'b1 || r_code !== 3'(exp_codes[i])) begin errors++; $display("FAIL rr_code%0d got valid %b code %0d want 1/%0d", i + 1, r_valid, r_code, exp_codes[i]); end
    end
    req = 8'h00;
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_hold_stability();
    do_reset();
    req = 8'h08;
    tick();
    req = 8'h00;
    tick();
    checks++; if (f_valid !== 1'b1 || f_code !== 3'd3) begin errors++; $display("FAIL hold_present got valid %b code %0d want 1/3", f_valid, f_code); end
    req = 8'h01;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (f_valid !== 1'b1 || f_code !== 3'd3) begin errors++; $display("FAIL hold_cycle%0d got valid %b code %0d want 1/3", i, f_valid, f_code); end
    end
    req = 8'h00;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    checks++; if (f_valid !== 1'b1 || f_code !== 3'd0) begin errors++; $display("FAIL hold_next got valid %b code %0d want 1/0", f_valid, f_code); end
  endtask

  task automatic test_set_wins_and_gating();
    do_reset();
    req = 8'h04;
    tick();
    req = 8'h00;
    tick();
    // Same-edge request on the acked line: stays pending, no overrun.
    req = 8'h04;
    ack = 1'b1;
    tick();
    req = 8'h00;
    ack = 1'b0;
    checks++; if (f_pending !== 8'h04 || f_valid !== 1'b0) begin errors++; $display("FAIL setwins_pending got pending %h valid %b want 04/0", f_pending, f_valid); end
    checks++; if (f_overrun !== 1'b0) begin errors++; $display("FAIL setwins_overrun got %b want 0", f_overrun); end
    tick();
    checks++; if (f_valid !== 1'b1 || f_code !== 3'd2) begin errors++; $display("FAIL setwins_represent got valid %b code %0d want 1/2", f_valid, f_code); end
    // Capture frozen: req ignored, presentation held.
    enable = 1'b0;
    req = 8'hFF;
    tick();
    tick();
    checks++; if (f_pending !== 8'h04 || f_overrun !== 1'b0) begin errors++; $display("FAIL gate_hold got pending %h overrun %b want 04/0", f_pending, f_overrun); end
    checks++; if (f_valid !== 1'b1 || f_code !== 3'd2) begin errors++; $display("FAIL gate_present got valid %b code %0d want 1/2", f_valid, f_code); end
    // Ack still retires while capture is frozen.
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    checks++; if (f_pending !== 8'h00 || f_valid !== 1'b0 || f_overrun !== 1'b0) begin errors++; $display("FAIL gate_ack got pending %h valid %b overrun %b want 00/0/0", f_pending, f_valid, f_overrun); end
    enable = 1'b1;
    req = 8'h00;
  endtask

  task automatic test_flush();
    do_reset();
    req = 8'h0C;
    tick();
    tick();
    req = 8'h00;
    checks++; if (f_valid !== 1'b1 || f_pending !== 8'h0C || f_overrun !== 1'b1) begin errors++; $display("FAIL flush_setup got valid %b pending %h overrun %b want 1/0c/1", f_valid, f_pending, f_overrun); end
    flush = 1'b1;
    req = 8'hFF;
    ack = 1'b1;
    tick();
    flush = 1'b0;
    req = 8'h00;
    ack = 1'b0;
    checks++; if (f_valid !== 1'b0 || f_pending !== 8'h00 || f_overrun !== 1'b0) begin errors++; $display("FAIL flush_clear got valid %b pending %h overrun %b want 0/00/0", f_valid, f_pending, f_overrun); end
    tick();
    checks++; if (f_valid !== 1'b0 || r_pending !== 8'h00) begin errors++; $display("FAIL flush_after got valid %b r_pending %h want 0/00", f_valid, r_pending); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 8'h42;
    tick();
    tick();
    req = 8'h00;
    checks++; if (f_valid !== 1'b1 || f_code !== 3'd1) begin errors++; $display("FAIL areset_setup got valid %b code %0d want 1/1", f_valid, f_code); end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++; if (f_valid !== 1'b0 || f_code !== 3'd0 || f_pending !== 8'h00 || f_overrun !== 1'b0) begin errors++; $display("FAIL areset_f got valid %b code %0d pending %h overrun %b want 0/0/00/0", f_valid, f_code, f_pending, f_overrun); end
    checks++; if (r_valid !== 1'b0 || r_code !== 3'd0 || r_pending !== 8'h00) begin errors++; $display("FAIL areset_r got valid %b code %0d pending %h want 0/0/00", r_valid, r_code, r_pending); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      req    = 8'($urandom & $urandom);
      enable = ($urandom_range(0, 9) != 0);
      flush  = ($urandom_range(0, 39) == 0);
      ack    = 1'($urandom_range(0, 1));
      tick();
      checks++; if (f_valid !== m_valid[0] || f_pending !== m_pend[0] || f_overrun !== m_ovr[0]) begin errors++; $display("FAIL rand_f%0d got v%b p%h o%b want v%b p%h o%b", cyc, f_valid, f_pending, f_overrun, m_valid[0], m_pend[0], m_ovr[0]); end
      checks++; if (r_valid !== m_valid[1] || r_pending !== m_pend[1] || r_overrun !== m_ovr[1]) begin errors++; $display("FAIL rand_r%0d got v%b p%h o%b want v%b p%h o%b", cyc, r_valid, r_pending, r_overrun, m_valid[1], m_pend[1], m_ovr[1]); end
      if (m_valid[0]) begin
        checks++; if (f_code !== 3'(m_code[0])) begin errors++; $display("FAIL rand_f_code%0d got %0d want %0d", cyc, f_code, m_code[0]); end
      end
      if (m_valid[1]) begin
        checks++; if (r_code !== 3'(m_code[1])) begin errors++; $display("FAIL rand_r_code%0d got %0d want %0d", cyc, r_code, m_code[1]); end
      end
    end
    req    = 8'h00;
    enable = 1'b1;
    flush  = 1'b0;
    ack    = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    req     = 8'h00;
    enable  = 1'b1;
    flush   = 1'b0;
    ack     = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_fixed_priority();
    test_round_robin();
    test_hold_stability();
    test_set_wins_and_gating();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/irq_encoder8_3.md
Name: irq_encoder8_3

Overview:
- Registered 8-to-3 priority encoder with request capture and a valid/ack handshake. It is the inverse of the 3-to-8 enable decoder.
- Collects up to eight one-hot or multi-hot event lines into a sticky pending register.
- Presents the index of one pending line on a 3-bit code bus. Clears that line when the consumer (control unit / exception sequencer) acknowledges it.

Parameters:
ROUND_ROBIN, 0, 0 = fixed priority (index 0 highest); 1 = rotating priority starting just above the last acknowledged index
RESET_LAST, 7, initial last-acknowledged index for round-robin mode (so index 0 wins first after reset)

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  asynchronous, active-low reset
req  input  8  event lines, sampled every rising edge; a high bit sets the matching pending bit
enable  input  1  high = capture requests and start new presentations; low = freeze capture/start
flush  input  1  synchronous clear of all pending bits and overrun; drops any current presentation
ack  input  1  consumer accepts the current code; only meaningful while valid=1
code  output  3  encoded index of the presented request
valid  output  1  code holds a pending request awaiting ack
pending  output  8  current pending register, registered
overrun  output  1  sticky; set when req[i]=1 while pending[i] is already 1
  - Cleared only by flush or reset.

Behaviour:
- Reset (reset_n=0, asynchronous): pending=0, code=0, valid=0, overrun=0, state=IDLE, last=RESET_LAST. All outputs hold these values until the first edge after reset_n rises.
- Capture, at each edge when enable=1: pending <= (pending & ~clr_mask) | req.
  - clr_mask is one-hot of code when valid&ack, otherwise 0.
  - Set wins over clear: a req on the acked bit in the same cycle leaves that bit pending.
- Overrun: set at an edge where enable=1 and (req & pending & ~clr_mask) != 0.
- Enable low: req is ignored (not captured, no overrun). A presentation already in progress stays valid and can still be acked; the ack clear is still applied.
- State machine, two states:
  - IDLE: valid=0. At an edge with enable=1, flush=0 and pending!=0, select an index: lowest set bit (fixed mode), or first set bit scanning upward from last+1 mod 8 (round-robin mode). Register it into code, set valid=1, go to PRESENT.
  - Selection uses the registered pending value, not the same-cycle req.
  - PRESENT: code and valid are held stable regardless of new req; no re-arbitration while valid. At an edge with ack=1: clear pending[code], last<=code, valid<=0, go to IDLE.
  - ack while in IDLE is ignored.
- Latency:
  - req high at edge k → pending bit visible after edge k → valid=1 after edge k+1.
  - After ack at edge m, valid=0 for one cycle; the next pending request is presented after edge m+1.
  - Maximum throughput is one acknowledged request every 2 cycles.
- Flush at an edge (priority over everything except reset): pending<=0, overrun<=0, valid<=0, state<=IDLE; code keeps its last value. The same-cycle req and ack are discarded.
- Reset asserted mid-presentation: immediate return to reset values; the pending request is lost.
- Wrap-around: round-robin scan from last+1 wraps 7→0.
- code is only defined while valid=1; verification compares code only when valid=1.

Test Plan:
- Single request: reset, enable=1, req=8'h20 for 1 cycle → pending=8'h20 after edge 1, valid=1 & code=5 after edge 2; ack 1 cycle → valid=0, pending=0.
- Fixed priority: req=8'h91 one cycle, ack whenever valid → codes presented 0, 4, 7 in order; valid low one cycle between each; pending ends 0.
- Round-robin (ROUND_ROBIN=1): req=8'h81 held continuously, ack each presentation → codes alternate 0,7,0,7; overrun=1 from the second capture edge.
- Hold stability: present code=3, then raise req=8'h01 without ack for 5 cycles → code stays 3, valid stays 1; after ack → next code=0.
- Set-wins and enable gating:
  - req=8'h04 on the same edge as ack of code=2 → pending[2]=1 and code=2 re-presented.
  - With enable=0, req=8'hFF → pending unchanged and overrun unchanged.
- Flush and async reset:
  - flush during PRESENT with pending=8'h0C → next cycle valid=0, pending=0, overrun=0.
  - reset_n low mid-cycle → outputs zero immediately, before any clock edge.
